// File: rtl/barrel_drop_pool.sv
// Pool of N_BARRELS vertically falling barrels that share one physics tick.
// Define BARREL_BOUNCE_EN to let each barrel bounce once off the floor before it lands.
module barrel_drop_pool #(
  parameter int N_BARRELS = 4,
  parameter int TICK_DIV  = 500000,
  parameter int START_Y   = 128,
  parameter int X_OFS     = 12,
  parameter int FLOOR_Y   = 736,
  parameter int V_MAX     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    launch_req,
  output logic                    launch_ready,
  input  logic [10:0]             xpos_kong,
  output logic [N_BARRELS-1:0]    active,
  output logic [N_BARRELS-1:0]    done,
  output logic [11*N_BARRELS-1:0] xpos,
  output logic [11*N_BARRELS-1:0] ypos
);

  localparam int            CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [11:0]   FLOOR12   = 12'(FLOOR_Y);
  localparam logic [10:0]   FLOOR11   = 11'(FLOOR_Y);
  localparam logic [10:0]   START11   = 11'(START_Y);
  localparam logic [10:0]   XOFS11    = 11'(X_OFS);
  localparam logic [5:0]    VMAX6     = 6'(V_MAX);

`ifdef BARREL_BOUNCE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FALL = 2'd1, S_RISE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FALL = 2'd1} state_t;
`endif

  logic [CW-1:0] count_q, count_d;
  logic          tick;

  state_t        state_q [N_BARRELS];
  state_t        state_d [N_BARRELS];
  logic [5:0]    vel_q   [N_BARRELS];
  logic [5:0]    vel_d   [N_BARRELS];
  logic [10:0]   x_q     [N_BARRELS];
  logic [10:0]   x_d     [N_BARRELS];
  logic [10:0]   y_q     [N_BARRELS];
  logic [10:0]   y_d     [N_BARRELS];
  logic [N_BARRELS-1:0] done_q, done_d;
`ifdef BARREL_BOUNCE_EN
  logic [N_BARRELS-1:0] bounced_q, bounced_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      done_q  <= '0;
`ifdef BARREL_BOUNCE_EN
      bounced_q <= '0;
`endif
      for (int i = 0; i < N_BARRELS; i++) begin
        state_q[i] <= S_IDLE;
        vel_q[i]   <= '0;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
      end
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
`ifdef BARREL_BOUNCE_EN
      bounced_q <= bounced_d;
`endif
      for (int i = 0; i < N_BARRELS; i++) begin
        state_q[i] <= state_d[i];
        vel_q[i]   <= vel_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
      end
    end
  end

  always_comb begin
    logic        taken;
    logic [11:0] sum;
    tick    = (count_q == TICK_LAST);
    count_d = tick ? '0 : count_q + CW'(1);
    taken   = 1'b0;
    sum     = '0;
    done_d  = '0;
`ifdef BARREL_BOUNCE_EN
    bounced_d = bounced_q;
`endif
    for (int i = 0; i < N_BARRELS; i++) begin
      state_d[i] = state_q[i];
      vel_d[i]   = vel_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      sum        = {1'b0, y_q[i]} + {6'd0, vel_q[i]};
      if (clear) begin
        state_d[i] = S_IDLE;
        vel_d[i]   = '0;
`ifdef BARREL_BOUNCE_EN
        bounced_d[i] = 1'b0;
`endif
      end else begin
        case (state_q[i])
          // Only the first idle slot seen in index order may take the launch.
          S_IDLE: begin
            if (!taken) begin
              taken = 1'b1;
              if (launch_req) begin
                state_d[i] = S_FALL;
                x_d[i]     = xpos_kong + XOFS11;
                y_d[i]     = START11;
                vel_d[i]   = '0;
`ifdef BARREL_BOUNCE_EN
                bounced_d[i] = 1'b0;
`endif
              end
            end
          end
          S_FALL: begin
            if (tick) begin
              if (sum >= FLOOR12) begin
                y_d[i] = FLOOR11;
`ifdef BARREL_BOUNCE_EN
                if (!bounced_q[i] && vel_q[i] >= 6'd2) begin
                  vel_d[i]     = vel_q[i] >> 1;
                  bounced_d[i] = 1'b1;
                  state_d[i]   = S_RISE;
                end else
`endif
                begin
                  vel_d[i]   = '0;
                  state_d[i] = S_IDLE;
                  done_d[i]  = 1'b1;
                end
              end else begin
                y_d[i]   = sum[10:0];
                vel_d[i] = (vel_q[i] >= VMAX6) ? VMAX6 : vel_q[i] + 6'd1;
              end
            end
          end
`ifdef BARREL_BOUNCE_EN
          S_RISE: begin
            if (tick) begin
              y_d[i]   = y_q[i] - {5'd0, vel_q[i]};
              vel_d[i] = vel_q[i] - 6'd1;
              if (vel_q[i] == 6'd1) state_d[i] = S_FALL;
            end
          end
`endif
          default: state_d[i] = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    launch_ready = 1'b0;
    active       = '0;
    xpos         = '0;
    ypos         = '0;
    for (int i = 0; i < N_BARRELS; i++) begin
      active[i]        = (state_q[i] != S_IDLE);
      launch_ready     = launch_ready | (state_q[i] == S_IDLE);
      xpos[11*i +: 11] = x_q[i];
      ypos[11*i +: 11] = y_q[i];
    end
    done = done_q;
  end

endmodule

// File: tb/tb_barrel_drop_pool.sv
// Bench for barrel_drop_pool: directed drop/pool/clear cases plus randomized traffic,
// every cycle compared against a plain-arithmetic barrel physics model.
module tb_barrel_drop_pool;
  localparam int N     = 4;
  localparam int TD    = 4;
  localparam int START = 128;
  localparam int XOFS  = 12;
  localparam int FLOOR = 736;
  localparam int VMAX  = 16;
`ifdef BARREL_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          launch_req;
  logic          launch_ready;
  logic [10:0]   xpos_kong;
  logic [N-1:0]  active;
  logic [N-1:0]  done;
  logic [11*N-1:0] xpos;
  logic [11*N-1:0] ypos;

  barrel_drop_pool #(
    .N_BARRELS(N), .TICK_DIV(TD), .START_Y(START),
    .X_OFS(XOFS), .FLOOR_Y(FLOOR), .V_MAX(VMAX)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .launch_req(launch_req),
    .launch_ready(launch_ready), .xpos_kong(xpos_kong), .active(active),
    .done(done), .xpos(xpos), .ypos(ypos)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state 0 idle, 1 falling, 2 rising.
  int mst [N];
  int mx  [N];
  int my  [N];
  int mv  [N];
  int mb  [N];
  bit mdone [N];
  int mcnt;

  task automatic model_step();
    bit tick;
    int pick;
    tick = (mcnt == TD - 1);
    pick = -1;
    mcnt = tick ? 0 : mcnt + 1;
    for (int i = 0; i < N; i++) begin
      mdone[i] = 1'b0;
      if (pick < 0 && mst[i] == 0) pick = i;
    end
    if (clear) begin
      for (int i = 0; i < N; i++) begin
        mst[i] = 0; mv[i] = 0; mb[i] = 0;
      end
      return;
    end
    if (tick) begin
      for (int i = 0; i < N; i++) begin
        if (mst[i] == 1) begin
          if (my[i] + mv[i] >= FLOOR) begin
            my[i] = FLOOR;
            if (BOUNCE && mb[i] == 0 && mv[i] >= 2) begin
              mv[i] = mv[i] / 2; mb[i] = 1; mst[i] = 2;
            end else begin
              mv[i] = 0; mst[i] = 0; mdone[i] = 1'b1;
            end
          end else begin
            my[i] = my[i] + mv[i];
            mv[i] = (mv[i] + 1 > VMAX) ? VMAX : mv[i] + 1;
          end
        end else if (mst[i] == 2) begin
          my[i] = my[i] - mv[i];
          mv[i] = mv[i] - 1;
          if (mv[i] == 0) mst[i] = 1;
        end
      end
    end
    if (launch_req && pick >= 0) begin
      mst[pick] = 1;
      mx[pick]  = (int'(xpos_kong) + XOFS) % 2048;
      my[pick]  = START;
      mv[pick]  = 0;
      mb[pick]  = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt = 0;
      for (int i = 0; i < N; i++) begin
        mst[i] = 0; mx[i] = 0; my[i] = 0; mv[i] = 0; mb[i] = 0; mdone[i] = 1'b0;
      end
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      bit any_idle;
      any_idle = 1'b0;
      for (int i = 0; i < N; i++) begin
        check($sformatf("active[%0d]", i), 64'(active[i]), 64'(mst[i] != 0));
        check($sformatf("done[%0d]", i), 64'(done[i]), 64'(mdone[i]));
        check($sformatf("xpos[%0d]", i), 64'(xpos[11*i +: 11]), 64'(mx[i]));
        check($sformatf("ypos[%0d]", i), 64'(ypos[11*i +: 11]), 64'(my[i]));
        if (mst[i] == 0) any_idle = 1'b1;
      end
      check("launch_ready", 64'(launch_ready), 64'(any_idle));
    end
  end

  int ys [$];
  int prev;
  bit got;

  initial begin
    clear = 1'b0; launch_req = 1'b0; xpos_kong = '0; rst = 1'b0;
    #1 rst = 1'b1;
    #12;
    check("rst_active", 64'(active), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_xpos", 64'(xpos), 64'd0);
    check("rst_ypos", 64'(ypos), 64'd0);
    check("rst_ready", 64'(launch_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Single drop from xpos_kong=100.
    xpos_kong = 11'd100;
    launch_req = 1'b1;
    @(negedge clk);
    launch_req = 1'b0;
    check("drop_x0", 64'(xpos[10:0]), 64'd112);
    check("drop_y0", 64'(ypos[10:0]), 64'd128);
    check("drop_act0", 64'(active[0]), 64'd1);
    prev = 128;
    got = 1'b0;
    for (int c = 0; c < 600 && !got; c++) begin
      @(negedge clk);
      if (int'(ypos[10:0]) != prev) begin
        prev = int'(ypos[10:0]);
        ys.push_back(prev);
      end
      if (done[0]) got = 1'b1;
    end
    check("drop_done_seen", 64'(got), 64'd1);
    check("drop_land_y", 64'(ypos[10:0]), 64'd736);
    if (BOUNCE) begin
      check("bnc_first_hit", 64'(ys[45]), 64'd736);
      check("bnc_rise1", 64'(ys[46]), 64'd728);
      check("bnc_rise2", 64'(ys[47]), 64'd721);
      check("bnc_rise3", 64'(ys[48]), 64'd715);
      check("bnc_apex", 64'(ys[53]), 64'd700);
    end else begin
      check("drop_nchanges", 64'(ys.size()), 64'd46);
      check("drop_tick46", 64'(ys[44]), 64'd728);
      check("drop_tick47", 64'(ys[45]), 64'd736);
    end
    @(negedge clk);
    check("drop_done_pulse", 64'(done[0]), 64'd0);
    check("drop_idle_after", 64'(active[0]), 64'd0);

    // Fill the pool, then hold the request until slot 0 frees up.
    launch_req = 1'b1;
    repeat (4) @(negedge clk);
    check("pool_full_act", 64'(active), 64'hF);
    check("pool_full_ready", 64'(launch_ready), 64'd0);
    got = 1'b0;
    for (int c = 0; c < 600 && !got; c++) begin
      @(negedge clk);
      if (done[0]) got = 1'b1;
    end
    check("pool_land_seen", 64'(got), 64'd1);
    @(negedge clk);
    check("pool_reload_act", 64'(active[0]), 64'd1);
    check("pool_reload_y", 64'(ypos[10:0]), 64'd128);

    // Clear with a launch pending.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    launch_req = 1'b0;
    check("clear_act", 64'(active), 64'd0);
    check("clear_done", 64'(done), 64'd0);

    // Randomized traffic.
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      launch_req = ($urandom_range(0, 99) < 25);
      clear      = ($urandom_range(0, 599) == 0);
      xpos_kong  = 11'($urandom);
      if (c == 4000 || $urandom_range(0, 2999) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    launch_req = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
